// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the fast_clk pipeline stages.
//   - s3_state_e  : stage-3 block accumulator FSM states (ACCUM / EMIT)
//   - S3_DATA_W   : default width of a stage-2 result sample
//   - S3_ACC_W    : default accumulator / block-sum width
//   - s2_sample_t : one stage-2 result sample at the default width
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int unsigned S3_DATA_W = 32'd8;
    localparam int unsigned S3_ACC_W  = 32'd16;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } s3_state_e;

    typedef logic [S3_DATA_W-1:0] s2_sample_t;

endpackage : pipeline_pkg

// File: rtl/s3_sync_fifo.sv
// ---------------------------------------------------------------------------
// s3_sync_fifo
// Single-clock FIFO buffering stage-2 results ahead of the block accumulator.
// Read data is the registered head entry, so a word written at one edge is
// visible to the reader only after that edge (never popped in the same cycle
// it was pushed into an empty FIFO).
//
// Ports:
//   clk      in   clock, all updates on rising edge
//   rst      in   synchronous active-high reset (pointers and level cleared)
//   push     in   write request; ignored while full
//   wr_data  in   DATA_W  word to write
//   pop      in   read request; ignored while empty
//   rd_data  out  DATA_W  head entry
//   full     out  level == DEPTH
//   empty    out  level == 0
//   level    out  clog2(DEPTH)+1  current occupancy
// ---------------------------------------------------------------------------
module s3_sync_fifo #(
    parameter int unsigned DATA_W = 32'd8,
    parameter int unsigned DEPTH  = 32'd4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 32'd1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == {LVL_W{1'b0}});
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Qualify requests against the registered full/empty flags.
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
    end

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LVL_W'(1'b1);
            2'b01:   level_d = level_q - LVL_W'(1'b1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule : s3_sync_fifo

// File: rtl/s3_block_accumulator.sv
// ---------------------------------------------------------------------------
// s3_block_accumulator
// Stage 3 of the fast_clk pipeline. Buffers stage-2 result samples in a small
// FIFO, sums every BLOCK_LEN samples and presents each block sum on a
// valid/ready output port.
//
// Build option:
//   S3_SATURATE_EN  defined   -> accumulation saturates at 2^ACC_W-1
//                   undefined -> accumulation wraps modulo 2^ACC_W
//
// Ports:
//   fast_clk    in   sole clock
//   rst         in   synchronous active-high reset
//   in_valid    in   stage-2 result valid
//   in_data     in   DATA_W  stage-2 result value
//   in_ready    out  FIFO can accept a sample (not full; no same-cycle pop look-ahead)
//   out_valid   out  block sum available (registered)
//   out_data    out  ACC_W  block sum (registered, stable while out_valid)
//   out_ready   in   downstream accepts the block sum
//   blk_count   out  8  emitted block count, wraps 255 -> 0
//   fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy
// ---------------------------------------------------------------------------
module s3_block_accumulator
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W    = S3_DATA_W,
    parameter int unsigned DEPTH     = 32'd4,
    parameter int unsigned BLOCK_LEN = 32'd4,
    parameter int unsigned ACC_W     = S3_ACC_W
) (
    input  logic                       fast_clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [ACC_W-1:0]           out_data,
    input  logic                       out_ready,
    output logic [7:0]                 blk_count,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 32'd1);

    s3_state_e          state_q,     state_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q,  out_data_d;
    logic [7:0]         blk_count_q, blk_count_d;

    logic               pop_s;
    logic [ACC_W-1:0]   sum_s;
    logic [DATA_W-1:0]  head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    // Add one zero-extended sample into the running sum.
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
`ifdef S3_SATURATE_EN
        logic [ACC_W:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        if (wide[ACC_W]) begin
            return {ACC_W{1'b1}};
        end else begin
            return wide[ACC_W-1:0];
        end
`else
        return a + b;
`endif
    endfunction

    s3_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (fast_clk),
        .rst     (rst),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

    assign in_ready  = ~fifo_full_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign blk_count = blk_count_q;

    // FSM next state, accumulator, sample counter and output register.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        blk_count_d = blk_count_q;
        pop_s       = 1'b0;
        sum_s       = acc_add(acc_q, ACC_W'(head_s));
        case (state_q)
            ST_ACCUM: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    acc_d = sum_s;
                    cnt_d = cnt_q + CNT_W'(1'b1);
                    if (cnt_q == CNT_W'(BLOCK_LEN - 32'd1)) begin
                        // Final sample of the block: the sum including the head
                        // goes straight into the output register.
                        state_d     = ST_EMIT;
                        out_data_d  = sum_s;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_d     = ST_ACCUM;
                    out_valid_d = 1'b0;
                    acc_d       = {ACC_W{1'b0}};
                    cnt_d       = {CNT_W{1'b0}};
                    blk_count_d = blk_count_q + 8'd1;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d     = ST_ACCUM;
                out_valid_d = 1'b0;
                acc_d       = {ACC_W{1'b0}};
                cnt_d       = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {ACC_W{1'b0}};
            blk_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            blk_count_q <= blk_count_d;
        end
    end

endmodule : s3_block_accumulator

// File: tb/tb_s3_block_accumulator.sv
// ---------------------------------------------------------------------------
// tb_s3_block_accumulator
// Self-checking bench for s3_block_accumulator (defaults) plus a second
// instance with ACC_W=9 for the width-limit case. Honours S3_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_s3_block_accumulator;
    import pipeline_pkg::*;

    localparam int ACC_W = 16;
    localparam int BLEN  = 4;

    logic        fast_clk = 1'b0;
    logic        rst      = 1'b0;
    logic        in_valid = 1'b0;
    s2_sample_t  in_data  = 8'd0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic [7:0]  blk_count;
    logic [2:0]  fifo_level;

    logic        in_valid9  = 1'b0;
    logic [7:0]  in_data9   = 8'd0;
    logic        in_ready9;
    logic        out_valid9;
    logic [8:0]  out_data9;
    logic        out_ready9 = 1'b0;
    logic [7:0]  blk_count9;
    logic [2:0]  fifo_level9;

    int n_checks = 0;
    int n_errors = 0;
    int n_push   = 0;
    int n_hs     = 0;
    int ov_seen  = 0;
    int ov_data  = 0;

    always #5 fast_clk = ~fast_clk;

    s3_block_accumulator dut (
        .fast_clk (fast_clk), .rst (rst),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready),
        .out_valid (out_valid), .out_data (out_data), .out_ready (out_ready),
        .blk_count (blk_count), .fifo_level (fifo_level)
    );

    s3_block_accumulator #(.ACC_W (9)) dut9 (
        .fast_clk (fast_clk), .rst (rst),
        .in_valid (in_valid9), .in_data (in_data9), .in_ready (in_ready9),
        .out_valid (out_valid9), .out_data (out_data9), .out_ready (out_ready9),
        .blk_count (blk_count9), .fifo_level (fifo_level9)
    );

    typedef struct {
        s2_sample_t  smp [BLEN];
        int unsigned sum;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: note handshakes seen before the edge, observe 1 time unit after it.
    task automatic tick();
        if (in_valid && in_ready)   n_push++;
        if (out_valid && out_ready) n_hs++;
        @(posedge fast_clk);
        #1;
        if (out_valid) begin
            ov_seen++;
            ov_data = int'(out_data);
        end
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_valid9  = 1'b0;
        out_ready9 = 1'b0;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
    endtask

    // Offer one sample and hold it until accepted (bounded).
    task automatic push_sample(input s2_sample_t v);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int k = 0; k < 50 && !done; k++) begin
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out(output logic ok);
        ok = out_valid;
        for (int k = 0; k < 40 && !ok; k++) begin
            tick();
            ok = out_valid;
        end
        if (!ok) chk("out_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic        ok;
        int          unstable;
        int          gap;
        int          sent;
        int          macc;
        int          mcnt;
        int          nblk;
        int unsigned exp_q [$];
        int          exp9;
        int          got9;
        logic        seen9;

        vecs[0].smp = '{8'd1,   8'd2,   8'd3,   8'd4};   vecs[0].sum = 10;
        vecs[1].smp = '{8'd0,   8'd0,   8'd0,   8'd0};   vecs[1].sum = 0;
        vecs[2].smp = '{8'd255, 8'd255, 8'd255, 8'd255}; vecs[2].sum = 1020;
        vecs[3].smp = '{8'd128, 8'd1,   8'd64,  8'd2};   vecs[3].sum = 195;
        vecs[4].smp = '{8'd17,  8'd34,  8'd51,  8'd68};  vecs[4].sum = 170;
        vecs[5].smp = '{8'd200, 8'd0,   8'd0,   8'd55};  vecs[5].sum = 255;

        // ---- reset state ----
        do_reset();
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_data",   32'(out_data),   32'd0);
        chk("rst_blk_count",  32'(blk_count),  32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_in_ready9",  32'(in_ready9),  32'd1);

        // ---- single block, out_valid exactly one cycle ----
        out_ready = 1'b1;
        ov_seen   = 0;
        for (int i = 1; i <= 4; i++) push_sample(s2_sample_t'(i));
        repeat (15) tick();
        chk("single_valid_cycles", 32'(ov_seen),   32'd1);
        chk("single_data",         32'(ov_data),   32'd10);
        chk("single_blk_count",    32'(blk_count), 32'd1);
        chk("single_level",        32'(fifo_level), 32'd0);

        // ---- table-driven blocks ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b0;
            for (int j = 0; j < BLEN; j++) push_sample(vecs[i].smp[j]);
            wait_out(ok);
            chk($sformatf("vec%0d_sum", i), 32'(out_data), vecs[i].sum);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("vec%0d_blk", i), 32'(blk_count), 32'(i + 1));
            chk($sformatf("vec%0d_ov_clr", i), 32'(out_valid), 32'd0);
        end

        // ---- backpressure ----
        do_reset();
        n_push   = 0;
        unstable = 0;
        in_valid = 1'b1;
        in_data  = 8'd5;
        repeat (16) begin
            tick();
            if (out_valid && out_data !== 16'd20) unstable++;
        end
        chk("bp_accepted",   32'(n_push),     32'd8);
        chk("bp_out_valid",  32'(out_valid),  32'd1);
        chk("bp_out_data",   32'(out_data),   32'd20);
        chk("bp_level",      32'(fifo_level), 32'd4);
        chk("bp_in_ready",   32'(in_ready),   32'd0);
        chk("bp_stable",     32'(unstable),   32'd0);
        n_hs      = 0;
        out_ready = 1'b1;
        tick();
        chk("bp_blk1", 32'(blk_count), 32'd1);
        for (int k = 0; k < 40 && n_hs < 2; k++) begin
            if (n_push >= 9) in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_handshakes", 32'(n_hs),      32'd2);
        chk("bp_second_sum", 32'(ov_data),   32'd20);
        chk("bp_ninth",      32'(n_push),    32'd9);
        chk("bp_blk2",       32'(blk_count), 32'd2);

        // ---- width limit, ACC_W=9 ----
        do_reset();
`ifdef S3_SATURATE_EN
        exp9 = 511;
`else
        exp9 = 508;
`endif
        in_valid9  = 1'b1;
        in_data9   = 8'd255;
        out_ready9 = 1'b1;
        repeat (4) tick();
        in_valid9 = 1'b0;
        seen9     = 1'b0;
        got9      = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid9 && !seen9) begin
                seen9 = 1'b1;
                got9  = int'(out_data9);
            end
            tick();
        end
        chk("w9_seen",  32'(seen9),       32'd1);
        chk("w9_sum",   32'(got9),        32'(exp9));
        chk("w9_blk",   32'(blk_count9),  32'd1);
        chk("w9_level", 32'(fifo_level9), 32'd0);

        // ---- reset mid-block ----
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_sample(8'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_level",     32'(fifo_level), 32'd0);
        chk("mr_out_valid", 32'(out_valid),  32'd0);
        chk("mr_blk0",      32'(blk_count),  32'd0);
        ov_seen = 0;
        for (int i = 0; i < 4; i++) push_sample(8'd1);
        repeat (15) tick();
        chk("mr_valid_cycles", 32'(ov_seen),   32'd1);
        chk("mr_sum",          32'(ov_data),   32'd4);
        chk("mr_blk1",         32'(blk_count), 32'd1);

        // ---- simultaneous push/pop at level 2 ----
        do_reset();
        for (int i = 1; i <= 6; i++) push_sample(s2_sample_t'(10 * i));
        chk("pp_level_emit", 32'(fifo_level), 32'd2);
        chk("pp_first_sum",  32'(out_data),   32'd100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pp_level_hs", 32'(fifo_level), 32'd2);
        for (int i = 7; i <= 10; i++) begin
            push_sample(s2_sample_t'(10 * i));
            chk($sformatf("pp_level_%0d", i), 32'(fifo_level), 32'd2);
        end
        wait_out(ok);
        chk("pp_order_sum1", 32'(out_data), 32'd260);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        push_sample(8'd110);
        push_sample(8'd120);
        wait_out(ok);
        chk("pp_order_sum2", 32'(out_data), 32'd420);

        // ---- bursty random traffic against a reference model ----
        do_reset();
        gap  = 0;
        sent = 0;
        macc = 0;
        mcnt = 0;
        nblk = 0;
        for (int cyc = 0; cyc < 20000 && nblk < 100; cyc++) begin
            if (!in_valid && gap == 0 && sent < 100 * BLEN) begin
                in_valid = 1'b1;
                in_data  = s2_sample_t'($urandom_range(0, 255));
            end
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
                macc = macc + int'(in_data);
`ifdef S3_SATURATE_EN
                if (macc > (1 << ACC_W) - 1) macc = (1 << ACC_W) - 1;
`else
                macc = macc % (1 << ACC_W);
`endif
                mcnt++;
                if (mcnt == BLEN) begin
                    exp_q.push_back(macc);
                    macc = 0;
                    mcnt = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_block", 32'd1, 32'd0);
                end else begin
                    chk($sformatf("rnd_blk%0d", nblk), 32'(out_data), exp_q.pop_front());
                end
                nblk++;
            end
            if (in_valid && in_ready) begin
                @(posedge fast_clk);
                #1;
                in_valid = 1'b0;
                sent++;
                gap = $urandom_range(0, 5);
            end else begin
                @(posedge fast_clk);
                #1;
                if (!in_valid && gap > 0) gap--;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rnd_blocks",    32'(nblk),         32'd100);
        chk("rnd_blk_count", 32'(blk_count),    32'(100 % 256));
        chk("rnd_leftover",  32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_s3_block_accumulator

// File: doc/s3_block_accumulator.md
Name: s3_block_accumulator

Overview:
- Stage 3 of the fast_clk pipeline. Sits directly downstream of stage 2 and consumes its result bytes.
- Buffers incoming stage-2 results in a small FIFO, which absorbs stage 2's variable output timing.
- Sums every BLOCK_LEN samples and presents each block sum on a valid/ready output port.
- Runs entirely in the fast_clk domain.

Parameters:
- DATA_W, 8: width of stage-2 result samples.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- BLOCK_LEN, 4: samples summed per emitted block; at least 1.
- ACC_W, 16: accumulator and block-sum width; at least DATA_W.

Ports:
- fast_clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  stage-2 result valid.
- in_data  in  DATA_W  stage-2 result value.
- in_ready  out  1  FIFO can accept a sample.
- out_valid  out  1  block sum available.
- out_data  out  ACC_W  block sum.
- out_ready  in  1  downstream accepts the block sum.
- blk_count  out  8  number of emitted blocks; wraps 255 -> 0.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values, sampled at the fast_clk edge with rst=1: state=ACCUM, FIFO empty, fifo_level=0, in_ready=1, out_valid=0, out_data=0, accumulator=0, sample counter=0, blk_count=0.
- Reset mid-block or mid-EMIT discards all buffered samples and the partial sum; no block is emitted.
- Push:
  - in_ready = !full. It is registered-state based only and does not look ahead to a same-cycle pop.
  - A push occurs when in_valid && in_ready. in_data is written at the write pointer, which then increments modulo DEPTH.
- Pop:
  - A pop occurs only in ACCUM, and only when the FIFO is not empty.
  - The head entry is added into the accumulator and the read pointer increments modulo DEPTH.
  - At most one pop per cycle.
- Push and pop in the same cycle leave fifo_level unchanged; both pointers advance.
- FIFO latency: a sample pushed at edge N is poppable at the earliest at edge N+1. A push into an empty FIFO is never popped in the same cycle.
- State machine has two states, ACCUM and EMIT.
- ACCUM:
  - Each pop increments the sample counter.
  - On the pop that makes the counter reach BLOCK_LEN, the next state is EMIT. out_data is loaded with the final sum (accumulator + head) and out_valid=1 from the following cycle.
- EMIT:
  - No pops occur; the FIFO keeps filling from stage 2 until full.
  - out_valid and out_data are held stable until out_valid && out_ready.
  - On that handshake: out_valid=0, accumulator=0, counter=0, blk_count+1, next state ACCUM.
  - The earliest next pop is the cycle after the handshake.
- Minimum spacing between block emissions is BLOCK_LEN+1 cycles.
- Arithmetic: samples are zero-extended to ACC_W. The sum wraps modulo 2^ACC_W unless the optional feature is enabled.
- Full FIFO: in_ready=0 and no data is dropped. Empty FIFO in ACCUM: no pop and the counter holds.

Optional Feature:
- S3_SATURATE_EN defined: accumulation saturates at 2^ACC_W-1, and a saturated block stays at max.
- S3_SATURATE_EN undefined: accumulation wraps modulo 2^ACC_W.
- Ports are identical in both builds.

Decomposition:
- Shared package pipeline_pkg holds:
  - the state enum for ACCUM and EMIT;
  - the default DATA_W and ACC_W constants;
  - the stage-2 sample type.
- One sub-module, s3_sync_fifo (parameters DATA_W, DEPTH), owns the storage, pointers, full/empty and level.
- The top holds the FSM, accumulator, counters and output register.

Test Plan:
- Single block, defaults: push 1,2,3,4 back-to-back with out_ready=1. Expect out_valid for exactly 1 cycle with out_data=10 and blk_count=1; out_valid=0 in all other cycles.
- Backpressure, defaults: hold out_ready=0 and offer 9 samples of value 5 back-to-back.
  - Expect out_data=20 and out_valid=1 held stable.
  - fifo_level rises to 4 and in_ready=0; the 9th sample stalls.
  - Raise out_ready: blk_count=1, then the second block 20 follows and the 9th sample is accepted.
- Width limit, ACC_W=9: push 255 x4.
  - With S3_SATURATE_EN: out_data=511.
  - Without S3_SATURATE_EN: out_data=508.
- Reset mid-operation: push 7,7,7 into the block, assert rst for 1 cycle, then push 1,1,1,1. Expect out_data=4 (not 25), blk_count=1, and fifo_level=0 immediately after reset.
- Bursty input: push samples with random 0-5 cycle gaps and random out_ready for 100 blocks. Expect every out_data to equal the reference-model sum of each BLOCK_LEN group, and blk_count=100 mod 256.
- Simultaneous push and pop at level 2 in ACCUM: expect fifo_level to stay at 2 and sample order to be preserved.
